// File: rtl/dbg_dump_uart_pkg.sv
// Shared definitions for the debug register dump engine: FSM state
// encodings, packet framing characters and the hex-to-ASCII encoder.
package dbg_dump_uart_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_START    = 4'd1,
        ST_READ     = 4'd2,
        ST_RWAIT    = 4'd3,
        ST_DIGIT    = 4'd4,
        ST_SEP      = 4'd5,
        ST_ENDP     = 4'd6,
        ST_TXSTROBE = 4'd7,
        ST_TXHOLD   = 4'd8,
        ST_DONE     = 4'd9
    } state_t;

    localparam logic [7:0] CH_P   = 8'h50;  // 'P'  packet start
    localparam logic [7:0] CH_SEP = 8'h2C;  // ','  register separator
    localparam logic [7:0] CH_EOL = 8'h0A;  // '\n' packet end

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/dbg_dump_uart_nib_shifter.sv
// Digit shifter for the dump engine: holds one captured register value,
// presents its top nibble and counts the hex digits still to be emitted.
module dbg_dump_uart_nib_shifter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic [3:0]        nib,
    output logic              empty
);

    localparam int NIB   = DATA_W / 4;
    localparam int CNT_W = $clog2(NIB + 1);

    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cnt;

    // Load a fresh register value, or move the next digit into the top nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            cnt  <= '0;
        end else if (load) begin
            data <= din;
            cnt  <= CNT_W'(NIB);
        end else if (shift) begin
            data <= data << 4;
            cnt  <= cnt - CNT_W'(1);
        end
    end

    assign nib   = data[DATA_W-1 -: 4];
    assign empty = (cnt == '0);

endmodule

// File: rtl/dbg_dump_uart.sv
// Debug register dump engine: on trig, reads registers regfirst..reglast
// from the debug file and streams them to a UART as "P<hex>,<hex>,...\n".
module dbg_dump_uart
    import dbg_dump_uart_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int NREGS    = 32,
    parameter  int READ_LAT = 1,
    localparam int SEL_W    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic [SEL_W-1:0]  regfirst,
    input  logic [SEL_W-1:0]  reglast,
    output logic              busy,
    output logic [SEL_W-1:0]  dbgsel,
    output logic              dbgreaden,
    input  logic [DATA_W-1:0] dbgout,
    input  logic              uartbusy,
    output logic [7:0]        charout,
    output logic              uarttxen
);

    state_t           state, state_nx, ret_st;
    logic [SEL_W-1:0] sel, last_q;
    logic [2:0]       cnt;
    logic [7:0]       char_q;
    logic             sh_load, sh_shift, sh_empty;
    logic [3:0]       sh_nib;

    // Indices beyond the register file (non-power-of-two NREGS) map to the last register.
    function automatic logic [SEL_W-1:0] clamp_idx(input logic [SEL_W-1:0] idx);
        if (int'(idx) > NREGS - 1) return SEL_W'(NREGS - 1);
        return idx;
    endfunction

    assign sh_load  = (state == ST_RWAIT) && (cnt == 3'(READ_LAT));
    assign sh_shift = (state == ST_DIGIT);

    dbg_dump_uart_nib_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (dbgout),
        .nib   (sh_nib),
        .empty (sh_empty)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; every byte goes through TXSTROBE/TXHOLD and then resumes at ret_st.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (trig) state_nx = ST_START;
            ST_START:    state_nx = ST_TXSTROBE;
            ST_READ:     state_nx = ST_RWAIT;
            ST_RWAIT:    if (cnt == 3'(READ_LAT)) state_nx = ST_DIGIT;
            ST_DIGIT,
            ST_SEP,
            ST_ENDP:     state_nx = ST_TXSTROBE;
            ST_TXSTROBE: if (!uartbusy) state_nx = ST_TXHOLD;
            ST_TXHOLD:   if ((cnt != 3'd0) && !uartbusy)
                             state_nx = ((ret_st == ST_DIGIT) && sh_empty) ? ST_SEP : ret_st;
            ST_DONE:     if (!trig) state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // Datapath registers: range latch, register index, byte to send, wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel    <= '0;
            last_q <= '0;
            cnt    <= '0;
            char_q <= '0;
            ret_st <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (trig) begin
                    sel    <= clamp_idx(regfirst);
                    last_q <= clamp_idx(reglast);
                end
                ST_START: begin
                    char_q <= CH_P;
                    ret_st <= (last_q < sel) ? ST_ENDP : ST_READ;
                end
                ST_READ:  cnt <= 3'd1;
                ST_RWAIT: cnt <= cnt + 3'd1;
                ST_DIGIT: begin
                    char_q <= hex_ascii(sh_nib);
                    ret_st <= ST_DIGIT;
                end
                ST_SEP: begin
                    char_q <= CH_SEP;
                    // Stop on the last index without incrementing so dbgsel never wraps.
                    if (sel == last_q) begin
                        ret_st <= ST_ENDP;
                    end else begin
                        ret_st <= ST_READ;
                        sel    <= sel + SEL_W'(1);
                    end
                end
                ST_ENDP: begin
                    char_q <= CH_EOL;
                    ret_st <= ST_DONE;
                end
                ST_TXSTROBE: cnt <= 3'd0;
                // First hold cycle arms the counter, giving a two-cycle minimum hold.
                ST_TXHOLD: if (cnt == 3'd0) cnt <= 3'd1;
                default: ;
            endcase
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy      = (state != ST_IDLE) && (state != ST_DONE);
        dbgreaden = (state == ST_READ);
        uarttxen  = (state == ST_TXSTROBE) && !uartbusy;
        dbgsel    = sel;
        charout   = char_q;
    end

endmodule
